// File: rtl/idct_pkg.sv
// IDCT sequencer shared types and constants.
// Lane vector layout and pipeline stage bundle.
package idct_pkg;

  localparam int LANES      = 4;
  localparam int DATA_W     = 8;
  localparam int PIPE_DEPTH = 4;
  localparam int INF_W      = $clog2(PIPE_DEPTH + 1);

  // lane k (1-based) sits at index k-1, bits [8k-1:8k-8]
  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  typedef struct packed {
    logic      v;
    lane_vec_t d;
  } pipe_stg_t;

  function automatic logic [INF_W-1:0] vld_count(
    input logic [PIPE_DEPTH-1:0] v
  );
    logic [INF_W-1:0] n;
    n = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      n = n + {{(INF_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/idct_res_fifo.sv
// IDCT result buffer: circular FIFO with occupancy count.
// Head reads as zero while empty.
module idct_res_fifo
  import idct_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // storage array, no reset needed: head is masked while empty
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers wrap naturally; count tells full from empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/idct_seq_ctrl.sv
// IDCT sequencer: skews lanes into a 4-tap datapath,
// buffers results and gates intake by credit.
module idct_seq_ctrl
  import idct_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BLK_LEN    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic [7:0]        dp_d_in_1,
  output logic [7:0]        dp_d_in_2,
  output logic [7:0]        dp_d_in_3,
  output logic [7:0]        dp_d_in_4,
  input  logic [7:0]        dp_d_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = CW + 1;
  localparam int BW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

  pipe_stg_t             stg [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] vld;
  logic [INF_W-1:0]      inflight;
  logic [CW-1:0]         fifo_count;
  logic [UW-1:0]         used;
  logic                  in_fire;
  logic                  out_fire;
  logic [BW-1:0]         blk_cnt;

  // gather per-stage valids for the credit count
  always_comb begin
    vld = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      vld[i] = stg[i].v;
    end
  end

  assign inflight = vld_count(vld);
  assign used     = UW'(fifo_count) + UW'(inflight);
  assign in_ready = reset & (used < UW'(FIFO_DEPTH));
  assign in_fire  = in_valid & in_ready;

  // token shift: bubbles carry zero data so idle lanes read 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0].v <= in_fire;
      stg[0].d <= in_fire ? lane_vec_t'(in_data) : '0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign dp_d_in_1 = stg[0].d[0];
  assign dp_d_in_2 = stg[1].d[1];
  assign dp_d_in_3 = stg[2].d[2];
  assign dp_d_in_4 = stg[3].d[3];

  assign out_valid = (fifo_count != '0);
  assign out_fire  = out_valid & out_ready;

  idct_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (stg[PIPE_DEPTH-1].v),
    .wr_data (dp_d_out),
    .rd_en   (out_fire),
    .rd_data (out_data),
    .count   (fifo_count)
  );

  // block position of the head result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_cnt <= '0;
    end else if (out_fire) begin
      if (blk_cnt == BW'(BLK_LEN - 1)) begin
        blk_cnt <= '0;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  assign out_last = out_valid & (blk_cnt == BW'(BLK_LEN - 1));
  assign busy     = (|vld) | out_valid;

endmodule

// File: tb/tb_idct_seq_ctrl.sv
// Bench for idct_seq_ctrl with adder-chain datapath stub.
// Scoreboard holds expected sums and their earliest cycle.
module tb_idct_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  dp_d_in_1, dp_d_in_2, dp_d_in_3, dp_d_in_4;
  logic [7:0]  dp_d_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  idct_seq_ctrl #(
    .FIFO_DEPTH (8),
    .BLK_LEN    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dp_d_in_1 (dp_d_in_1),
    .dp_d_in_2 (dp_d_in_2),
    .dp_d_in_3 (dp_d_in_3),
    .dp_d_in_4 (dp_d_in_4),
    .dp_d_out  (dp_d_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] acc1 = '0;
  logic [7:0] acc2 = '0;
  logic [7:0] acc3 = '0;

  always @(posedge clk) begin
    acc1 <= dp_d_in_1;
    acc2 <= acc1 + dp_d_in_2;
    acc3 <= acc2 + dp_d_in_3;
  end

  assign dp_d_out = acc3 + dp_d_in_4;

  logic [7:0] dpl [4];
  assign dpl[0] = dp_d_in_1;
  assign dpl[1] = dp_d_in_2;
  assign dpl[2] = dp_d_in_3;
  assign dpl[3] = dp_d_in_4;

  typedef struct {
    logic [7:0] d;
    int         avail;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mp [4];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          blk     = 0;
  int          n_acc   = 0;
  int          n_out   = 0;
  int          last_out_cyc = 0;
  int          last_acc_cyc = 0;
  logic [7:0]  last_out_data = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] vsum(input logic [31:0] d);
    return d[7:0] + d[15:8] + d[23:16] + d[31:24];
  endfunction

  task automatic step(input logic iv, input logic [31:0] d,
                      input logic ordy);
    logic exp_ov;
    logic inf;
    logic outf;
    logic [31:0] lane;
    @(negedge clk);
    cyc++;
    exp_ov = (sbq.size() > 0) && (sbq[0].avail <= cyc);
    chk("in_ready", 32'(in_ready), 32'(sbq.size() < 8));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("busy", 32'(busy), 32'(sbq.size() != 0));
    chk("out_last", 32'(out_last), 32'(exp_ov && blk == 3));
    if (exp_ov) chk("out_data", 32'(out_data), 32'(sbq[0].d));
    for (int k = 0; k < 4; k++) begin
      lane = (mp[k] >> (8 * k)) & 32'hff;
      chk("dp_lane", 32'(dpl[k]), lane);
    end
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    inf  = iv & in_ready;
    outf = out_valid & ordy;
    if (outf) begin
      if (sbq.size() > 0) void'(sbq.pop_front());
      blk = (blk + 1) % 4;
      n_out++;
      last_out_cyc  = cyc;
      last_out_data = out_data;
    end
    if (inf) begin
      sbq.push_back('{d: vsum(d), avail: cyc + 5});
      n_acc++;
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    mp[3] = mp[2];
    mp[2] = mp[1];
    mp[1] = mp[0];
    mp[0] = inf ? d : 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_lanes", {dp_d_in_4, dp_d_in_3, dp_d_in_2, dp_d_in_1}, 32'h0);
    sbq.delete();
    for (int k = 0; k < 4; k++) mp[k] = 32'h0;
    blk = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() > 0 && g < 200) begin
      step(1'b0, 32'h0, 1'b1);
      g++;
    end
    chk("drain_done", 32'(sbq.size()), 32'h0);
  endtask

  initial begin
    int a;
    int b;
    int g;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) mp[k] = 32'h0;

    do_reset();
    step(1'b1, 32'h04030201, 1'b1);
    a = last_acc_cyc;
    repeat (7) step(1'b0, 32'h0, 1'b1);
    chk("lat_cycles", 32'(last_out_cyc - a), 32'd5);
    chk("lat_data", 32'(last_out_data), 32'h0A);

    do_reset();
    a = n_acc;
    b = n_out;
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);
    chk("b2b_acc", 32'(n_acc - a), 32'd8);
    chk("b2b_out", 32'(n_out - b), 32'd8);

    do_reset();
    a = n_acc;
    repeat (20) step(1'b1, $urandom, 1'b0);
    chk("fill_acc", 32'(n_acc - a), 32'd8);
    chk("fill_stall", 32'(in_ready), 32'h0);
    drain();

    do_reset();
    repeat (5) step(1'b1, $urandom, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    do_reset();
    repeat (10) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h05050505, 1'b1);
    drain();
    chk("post_rst_data", 32'(last_out_data), 32'h14);

    do_reset();
    a = n_acc;
    g = 0;
    while ((n_acc - a) < 1000 && g < 20000) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)));
      g++;
    end
    chk("rand_acc", 32'((n_acc - a) >= 1000), 32'h1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idct_seq_ctrl.md
IDCT_SEQ_CTRL -- requirements
Module: idct_seq_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, result buffer entries (power of two, >= 5).
REQ-002 Parameter: BLK_LEN, 4, outputs per block; out_last marks the final one.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  coefficient vector offered.
REQ-006 in_ready  out  1  vector accepted when in_valid&in_ready at rising clk.
REQ-007 in_data  in  32  lane k (k=1..4) in bits [8k-1:8k-8].
REQ-008 dp_d_in_1..dp_d_in_4  out  8 each  skewed lane drive to the 4-tap datapath.
REQ-009 dp_d_out  in  8  datapath combinational result.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  result consumed when out_valid&out_ready at rising clk.
REQ-012 out_data  out  8  FIFO head result.
REQ-013 out_last  out  1  head is the BLK_LEN-th result of its block.
REQ-014 busy  out  1  any vector in flight or FIFO non-empty.

Function
REQ-015 Vector accepted at edge T SHALL drive lane1 during cycle T+1, lane2 T+2, lane3 T+3, lane4 T+4, each from a register (no combinational in->dp path).
REQ-016 Lanes with no valid token in that slot SHALL drive 8'h00 (bubble).
REQ-017 A 4-stage valid shift register SHALL track tokens; stage-4 valid SHALL write dp_d_out into the FIFO at edge ending T+4.
REQ-018 Accept-to-out_valid latency SHALL be 5 cycles with empty FIFO.
REQ-019 in_ready SHALL be combinational from state only: (fifo_count + inflight_count) < FIFO_DEPTH; independent of in_valid and out_ready.
REQ-020 With out_ready held 1, throughput SHALL be one vector per cycle, no stalls.
REQ-021 FIFO write and pop in the same cycle SHALL both take effect; count unchanged.
REQ-022 FIFO SHALL never overflow; out_ready low indefinitely SHALL stall in_ready only, never drop or corrupt results.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by count.
REQ-024 out_data/out_valid SHALL remain stable while out_valid&!out_ready.
REQ-025 Block counter SHALL advance per output handshake, wrap 0..BLK_LEN-1; out_last = (counter == BLK_LEN-1) & out_valid.
REQ-026 Results SHALL be delivered in acceptance order.

Reset
REQ-027 On reset low: in_ready 1 after release conditions met (count 0), out_valid 0, out_data 0, out_last 0, busy 0, all dp_d_in 0, valid pipe clear, FIFO empty, block counter 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight and buffered results; no result from before reset SHALL appear afterwards.
REQ-029 During reset in_ready SHALL be 0.

Structure
REQ-030 Shared package idct_pkg SHALL hold LANES=4, DATA_W=8, PIPE_DEPTH=4 and the lane-vector typedef.
REQ-031 Result buffer SHALL be a sub-module idct_res_fifo (parameterised depth, count output); skew and credit logic stay top-level.

Verification
Bench datapath stub: registered adder chain, identity multipliers (d_out = lane1+lane2+lane3+lane4 with matching skew).
REQ-032 Single vector {1,2,3,4} accepted at cycle 0 -> out_valid first high cycle 5, out_data 0x0A, out_last 0.
REQ-033 8 back-to-back vectors, out_ready=1 -> in_ready never drops, 8 results on consecutive cycles, out_last on 4th and 8th.
REQ-034 out_ready=0, in_valid=1 continuously -> exactly 8 vectors accepted, in_ready 0 thereafter, no loss; raising out_ready drains all 8 in order.
REQ-035 Reset pulsed with 3 in flight and 2 buffered -> outputs match REQ-027 next cycle; after release no stale result appears; next vector {5,5,5,5} yields 0x14.
REQ-036 Alternating in_valid and out_ready toggling (random, 1000 vectors) -> scoreboard order/data match, FIFO count never exceeds 8, dp lanes 0 in bubble slots.
